// File: rtl/wbu_pkg.sv
// Write-back stage shared definitions.
// Retire packet layout (shared with the load/store stage), write-back source
// select encoding, buffer FSM states and the write-back data selector.
package wbu_pkg;

    localparam int XLEN    = 32;
    localparam int PKT_W   = 104;
    localparam int ALU_LSB = 72;   // [103:72] alu_result / address
    localparam int MEM_LSB = 40;   // [71:40]  mem_rdata, already extended
    localparam int RD_LSB  = 35;   // [39:35]  rd
    localparam int WEN_BIT = 34;   // [34]     rd_wen
    localparam int SEL_LSB = 32;   // [33:32]  wb_sel
    localparam int PC_LSB  = 0;    // [31:0]   pc
    localparam int REG_AW  = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_t;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } wbu_state_t;

    // Field order matches the bit offsets above, MSB first.
    typedef struct packed {
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   mem_rdata;
        logic [REG_AW-1:0] rd;
        logic              rd_wen;
        logic [1:0]        wb_sel;    // 2'b11 is reserved and falls back to alu
        logic [XLEN-1:0]   pc;
    } wbu_pkt_t;

    function automatic logic [XLEN-1:0] wb_data(input wbu_pkt_t p);
        case (p.wb_sel)
            WB_MEM:  wb_data = p.mem_rdata;
            WB_PC4:  wb_data = p.pc + XLEN'(4);
            default: wb_data = p.alu;
        endcase
    endfunction

endpackage

// File: rtl/wbu_if.sv
// Write-back stage bus bundle.
// Groups upstream packet handshake, fetch-stage commit handshake, decode read
// ports and commit trace outputs. slave = write-back stage, master = its
// surrounding pipeline (or a bench standing in for it).
interface wbu_if;

    logic                         lsu_valid;
    logic [wbu_pkg::PKT_W-1:0]    lsu_data;
    logic                         wbu_ready;
    logic                         wbu_valid;
    logic [wbu_pkg::XLEN-1:0]     wbu_next_pc;
    logic                         ifu_ready;
    logic [wbu_pkg::REG_AW-1:0]   rs1_addr;
    logic [wbu_pkg::REG_AW-1:0]   rs2_addr;
    logic [wbu_pkg::XLEN-1:0]     rs1_data;
    logic [wbu_pkg::XLEN-1:0]     rs2_data;
    logic                         commit_pulse;
    logic [wbu_pkg::XLEN-1:0]     commit_pc;
    logic [63:0]                  retire_cnt;

    modport slave (
        input  lsu_valid, lsu_data, ifu_ready, rs1_addr, rs2_addr,
        output wbu_ready, wbu_valid, wbu_next_pc, rs1_data, rs2_data,
               commit_pulse, commit_pc, retire_cnt
    );

    modport master (
        output lsu_valid, lsu_data, ifu_ready, rs1_addr, rs2_addr,
        input  wbu_ready, wbu_valid, wbu_next_pc, rs1_data, rs2_data,
               commit_pulse, commit_pc, retire_cnt
    );

endinterface

// File: rtl/wbu_gpr_file.sv
// General-purpose register file.
// Ports: clk, rst (async, active-high, clears all registers); one synchronous
// write port (we/waddr/wdata); two combinational read ports (raddr*/rdata*).
// x0 is a constant zero: writes to it are dropped and it always reads 0.
// Reads see the pre-write value in the cycle of a write; there is no bypass.
module gpr_file #(
    parameter int WIDTH   = 32,
    parameter int NR_REGS = 32,
    parameter int AW      = $clog2(NR_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] regs [NR_REGS];

    assign regs[0] = '0;

    for (genvar i = 1; i < NR_REGS; i++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                regs[i] <= '0;
            else if (we && waddr == AW'(i))
                regs[i] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/wbu.sv
// Write-back stage.
// Ports: clk, rst (async, active-high); bus (wbu_if.slave) carrying the
// load/store packet handshake (lsu_valid/lsu_data/wbu_ready), the fetch-stage
// commit handshake (wbu_valid/wbu_next_pc/ifu_ready), decode GPR read ports
// and commit trace outputs (commit_pulse/commit_pc/retire_cnt).
// A one-entry buffer holds the retiring instruction; on commit the GPR is
// written and the buffer may be refilled on the same edge.
module wbu
    import wbu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NR_REGS = 32
) (
    input  logic  clk,
    input  logic  rst,
    wbu_if.slave  bus
);

    wbu_state_t state, state_nxt;
    wbu_pkt_t   pkt;
    logic       valid;
    logic       ready;
    logic       accept;
    logic       commit;
    logic       gpr_we;

    assign valid  = (state == S_FULL);
    // Refill is allowed in the commit cycle, so the stage sustains one per clock.
    assign ready  = ~valid | (valid & bus.ifu_ready);
    assign accept = bus.lsu_valid & ready;
    assign commit = valid & bus.ifu_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: if (accept) state_nxt = S_FULL;
            S_FULL:  if (commit) state_nxt = accept ? S_FULL : S_EMPTY;
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pkt <= '0;
        else if (accept)
            pkt <= wbu_pkt_t'(bus.lsu_data);
    end

    // commit_pc holds its last value; it is meaningful only while commit_pulse is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.commit_pulse <= 1'b0;
            bus.commit_pc    <= '0;
            bus.retire_cnt   <= '0;
        end else begin
            bus.commit_pulse <= commit;
            if (commit) begin
                bus.commit_pc  <= pkt.pc;
                bus.retire_cnt <= bus.retire_cnt + 64'd1;
            end
        end
    end

    assign gpr_we = commit & pkt.rd_wen & (pkt.rd != '0);

    gpr_file #(
        .WIDTH   (WIDTH),
        .NR_REGS (NR_REGS)
    ) u_gpr (
        .clk    (clk),
        .rst    (rst),
        .we     (gpr_we),
        .waddr  (pkt.rd),
        .wdata  (wb_data(pkt)),
        .raddr1 (bus.rs1_addr),
        .rdata1 (bus.rs1_data),
        .raddr2 (bus.rs2_addr),
        .rdata2 (bus.rs2_data)
    );

    assign bus.wbu_ready   = ready;
    assign bus.wbu_valid   = valid;
    assign bus.wbu_next_pc = pkt.pc + XLEN'(4);

endmodule
